mcu_block_sched: RTL and testbench

MCU_BLOCK_SCHED -- requirements
Module: mcu_block_sched

---
 rtl/mcu_block_sched_pkg.sv | 36 +++
 rtl/mcu_block_sched_if.sv | 34 +++
 rtl/mcu_row_mux.sv | 56 +++++
 rtl/mcu_block_sched.sv | 120 ++++++++++++
 tb/tb_mcu_block_sched.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcu_block_sched_pkg.sv
// Shared JPEG encoder definitions: component and chroma-mode enums, MCU slot tables and the
// block geometry constants used by the MCU block scheduler.
package mcu_block_sched_pkg;

    localparam int unsigned ROWS_PER_BLK = 8;
    localparam int unsigned MAX_SLOTS    = 6;

    typedef enum logic [1:0] {
        CompY  = 2'd0,
        CompCb = 2'd1,
        CompCr = 2'd2
    } comp_e;

    typedef enum logic {
        Mode420 = 1'b0,
        Mode422 = 1'b1
    } chroma_mode_e;

    // Entry [i] is the component carried by slot i of one MCU.
    localparam logic [MAX_SLOTS-1:0][1:0] SLOT_TBL_420 = {2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
    localparam logic [MAX_SLOTS-1:0][1:0] SLOT_TBL_422 = {2'd0, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0};

    function automatic comp_e slot_comp(chroma_mode_e mode, logic [2:0] slot);
        comp_e c;
        c = CompY;
        if (int'(slot) < MAX_SLOTS) begin
            c = (mode == Mode422) ? comp_e'(SLOT_TBL_422[slot]) : comp_e'(SLOT_TBL_420[slot]);
        end
        return c;
    endfunction

    function automatic logic [2:0] last_slot(chroma_mode_e mode);
        return (mode == Mode422) ? 3'd3 : 3'd5;
    endfunction

endpackage

// File: rtl/mcu_block_sched_if.sv
// Row-level handshake bundle between the Y/Cb/Cr row sources, the scheduler and the
// transpose/DCT stage.
interface mcu_block_sched_if #(
    parameter int unsigned QW        = 12,
    parameter int unsigned NCOMP_LOG = 2
);
    logic [8*QW-1:0]      y_d;
    logic                 y_valid;
    logic                 y_hold;
    logic [8*QW-1:0]      cb_d;
    logic                 cb_valid;
    logic                 cb_hold;
    logic [8*QW-1:0]      cr_d;
    logic                 cr_valid;
    logic                 cr_hold;
    logic [8*QW-1:0]      q;
    logic [2:0]           q_cnt;
    logic [NCOMP_LOG-1:0] q_comp;
    logic [2:0]           q_blk;
    logic                 q_valid;
    logic                 q_hold;
    logic                 mcu_done;

    modport master (
        output y_d, y_valid, cb_d, cb_valid, cr_d, cr_valid, q_hold,
        input  y_hold, cb_hold, cr_hold, q, q_cnt, q_comp, q_blk, q_valid, mcu_done
    );

    modport slave (
        input  y_d, y_valid, cb_d, cb_valid, cr_d, cr_valid, q_hold,
        output y_hold, cb_hold, cr_hold, q, q_cnt, q_comp, q_blk, q_valid, mcu_done
    );

endinterface

// File: rtl/mcu_row_mux.sv
// Combinational component selector: routes the slot's row port to the scheduler and raises
// hold on every port that may not deliver a row this cycle.
module mcu_row_mux
    import mcu_block_sched_pkg::*;
#(
    parameter int unsigned QW = 12
) (
    input  logic           run,
    input  comp_e          comp,
    input  logic           out_stall,
    input  logic [8*QW-1:0] y_d,
    input  logic           y_valid,
    input  logic [8*QW-1:0] cb_d,
    input  logic           cb_valid,
    input  logic [8*QW-1:0] cr_d,
    input  logic           cr_valid,
    output logic           y_hold,
    output logic           cb_hold,
    output logic           cr_hold,
    output logic           accept,
    output logic [8*QW-1:0] row
);

    logic sel_valid;
    logic sel_hold;

    assign sel_hold = ~run | out_stall;

    always_comb begin
        y_hold    = 1'b1;
        cb_hold   = 1'b1;
        cr_hold   = 1'b1;
        sel_valid = 1'b0;
        row       = y_d;
        unique case (comp)
            CompY: begin
                row       = y_d;
                sel_valid = y_valid;
                y_hold    = sel_hold;
            end
            CompCb: begin
                row       = cb_d;
                sel_valid = cb_valid;
                cb_hold   = sel_hold;
            end
            CompCr: begin
                row       = cr_d;
                sel_valid = cr_valid;
                cr_hold   = sel_hold;
            end
            default: ;
        endcase
        accept = sel_valid & ~sel_hold;
    end

endmodule

// File: rtl/mcu_block_sched.sv
// MCU block scheduler: walks the 4:2:0 / 4:2:2 slot table, pulls one 8-sample row per cycle
// from the selected component port and registers it towards the transpose/DCT stage.
module mcu_block_sched
    import mcu_block_sched_pkg::*;
#(
    parameter int unsigned QW        = 12,
    parameter int unsigned NCOMP_LOG = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             mode,
    mcu_block_sched_if.slave bus
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e               state;
    chroma_mode_e         mode_lat;
    logic [2:0]           row_cnt;
    logic [2:0]           slot;
    logic [8*QW-1:0]      q_r;
    logic [2:0]           q_cnt_r;
    logic [NCOMP_LOG-1:0] q_comp_r;
    logic [2:0]           q_blk_r;
    logic                 q_valid_r;
    logic                 q_last;

    comp_e           cur_comp;
    logic            accept;
    logic [8*QW-1:0] row_sel;
    logic            blk_end;
    logic            mcu_end;
    logic            xfer;

    assign cur_comp = slot_comp(mode_lat, slot);
    assign blk_end  = (row_cnt == 3'(ROWS_PER_BLK - 1));
    assign mcu_end  = blk_end && (slot == last_slot(mode_lat));
    assign xfer     = q_valid_r & ~bus.q_hold;

    mcu_row_mux #(
        .QW(QW)
    ) u_row_mux (
        .run       (state == StRun),
        .comp      (cur_comp),
        .out_stall (q_valid_r & bus.q_hold),
        .y_d       (bus.y_d),
        .y_valid   (bus.y_valid),
        .cb_d      (bus.cb_d),
        .cb_valid  (bus.cb_valid),
        .cr_d      (bus.cr_d),
        .cr_valid  (bus.cr_valid),
        .y_hold    (bus.y_hold),
        .cb_hold   (bus.cb_hold),
        .cr_hold   (bus.cr_hold),
        .accept    (accept),
        .row       (row_sel)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= StIdle;
            mode_lat  <= Mode420;
            row_cnt   <= '0;
            slot      <= '0;
            q_r       <= '0;
            q_cnt_r   <= '0;
            q_comp_r  <= '0;
            q_blk_r   <= '0;
            q_valid_r <= 1'b0;
            q_last    <= 1'b0;
        end else begin
            if (accept) begin
                q_r       <= row_sel;
                q_cnt_r   <= row_cnt;
                q_comp_r  <= NCOMP_LOG'(cur_comp);
                q_blk_r   <= slot;
                q_last    <= mcu_end;
                q_valid_r <= 1'b1;
            end else if (xfer) begin
                q_valid_r <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    if (en) begin
                        state    <= StRun;
                        mode_lat <= chroma_mode_e'(mode);
                        row_cnt  <= '0;
                        slot     <= '0;
                    end
                end
                StRun: begin
                    if (accept) begin
                        row_cnt <= row_cnt + 3'd1;
                        if (blk_end) begin
                            slot <= mcu_end ? 3'd0 : slot + 3'd1;
                        end
                        // MCU boundary: the only point where mode and en take effect.
                        if (mcu_end) begin
                            mode_lat <= chroma_mode_e'(mode);
                            if (!en) begin
                                state <= StIdle;
                            end
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.q        = q_r;
    assign bus.q_cnt    = q_cnt_r;
    assign bus.q_comp   = q_comp_r;
    assign bus.q_blk    = q_blk_r;
    assign bus.q_valid  = q_valid_r;
    assign bus.mcu_done = xfer & q_last;

endmodule

// File: tb/tb_mcu_block_sched.sv
// Self-checking bench for mcu_block_sched: table-driven MCU runs plus hand-written stall,
// mode-change, en-drop and reset sequences, all checked through an expected-row scoreboard.
module tb_mcu_block_sched;

    localparam int QW  = 12;
    localparam int NCL = 2;

    typedef logic [8*QW-1:0] row_t;

    typedef struct {
        row_t data;
        int   comp;
        int   blk;
        int   cnt;
        bit   last;
    } exp_t;

    typedef struct {
        bit mode;
        bit rnd;
        int exp_xfer;
        int exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    logic en;
    logic mode;

    mcu_block_sched_if #(.QW(QW), .NCOMP_LOG(NCL)) bus ();

    mcu_block_sched #(
        .QW        (QW),
        .NCOMP_LOG (NCL)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .en     (en),
        .mode   (mode),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_xfer  = 0;
    int   n_done  = 0;
    int   y_sent  = 0;
    int   cb_sent = 0;
    int   cr_sent = 0;
    int   mcnt[3] = '{0, 0, 0};
    bit   manual_hold = 1'b0;
    bit   rnd_en      = 1'b0;
    bit   mon_on      = 1'b0;

    int tbl420[6] = '{0, 0, 0, 0, 1, 2};
    int tbl422[4] = '{0, 0, 1, 2};

    function automatic row_t pat(int comp, int k);
        row_t r;
        for (int i = 0; i < 8; i++) begin
            r[i*QW +: QW] = QW'((comp + 1) * 517 + k * 97 + i * 301 - 1800);
        end
        return r;
    endfunction

    task automatic chk(string name, row_t act, row_t expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Each port's data is the next row of its own numbered stream.
    assign bus.y_d  = pat(0, y_sent);
    assign bus.cb_d = pat(1, cb_sent);
    assign bus.cr_d = pat(2, cr_sent);

    always @(posedge clk) begin
        if (bus.y_valid === 1'b1 && bus.y_hold === 1'b0) y_sent <= y_sent + 1;
        if (bus.cb_valid === 1'b1 && bus.cb_hold === 1'b0) cb_sent <= cb_sent + 1;
        if (bus.cr_valid === 1'b1 && bus.cr_hold === 1'b0) cr_sent <= cr_sent + 1;
    end

    always begin
        bus.q_hold   = manual_hold | (rnd_en && $urandom_range(0, 2) == 0);
        bus.y_valid  = !(rnd_en && $urandom_range(0, 3) == 0);
        bus.cb_valid = !(rnd_en && $urandom_range(0, 3) == 0);
        bus.cr_valid = !(rnd_en && $urandom_range(0, 3) == 0);
        @(negedge clk);
        #1;
    end

    // Output monitor: every transfer is popped from the scoreboard and compared.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (mon_on) begin
            if (bus.q_valid === 1'b1 && bus.q_hold === 1'b0) begin
                n_xfer++;
                if (bus.mcu_done === 1'b1) n_done++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_xfer: got row cnt=%0d blk=%0d, expected none",
                             bus.q_cnt, bus.q_blk);
                end else begin
                    e = exp_q.pop_front();
                    chk("q_data", bus.q, e.data);
                    chk("q_cnt", row_t'(bus.q_cnt), row_t'(e.cnt));
                    chk("q_comp", row_t'(bus.q_comp), row_t'(e.comp));
                    chk("q_blk", row_t'(bus.q_blk), row_t'(e.blk));
                    chk("mcu_done", row_t'(bus.mcu_done), row_t'(e.last));
                end
            end else begin
                chk("mcu_done_no_xfer", row_t'(bus.mcu_done), row_t'(0));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #3;
    endtask

    task automatic push_mcu(bit m);
        int ns;
        int c;
        ns = m ? 4 : 6;
        for (int s = 0; s < ns; s++) begin
            c = m ? tbl422[s] : tbl420[s];
            for (int r = 0; r < 8; r++) begin
                exp_q.push_back('{pat(c, mcnt[c]), c, s, r, (s == ns - 1 && r == 7)});
                mcnt[c]++;
            end
        end
    endtask

    task automatic drain(int limit);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < limit) begin
            step();
            t++;
        end
        chk("drain_rows_left", row_t'(exp_q.size()), row_t'(0));
        exp_q.delete();
    endtask

    task automatic wait_row(int comp, int blk, int cnt);
        int  t;
        bit  found;
        t = 0;
        found = 1'b0;
        while (!found && t < 500) begin
            step();
            t++;
            found = (bus.q_valid === 1'b1) && (int'(bus.q_comp) == comp) &&
                    (int'(bus.q_blk) == blk) && (int'(bus.q_cnt) == cnt);
        end
        chk("wait_row_found", row_t'(found), row_t'(1));
    endtask

    task automatic run_mcu(bit m);
        push_mcu(m);
        mode = m;
        en   = 1'b1;
        step();
        en   = 1'b0;
        drain(2000);
    endtask

    vec_t vecs[4];

    initial begin
        int x0;
        int d0;
        int t;

        vecs[0] = '{1'b0, 1'b0, 48, 1};
        vecs[1] = '{1'b1, 1'b0, 32, 1};
        vecs[2] = '{1'b0, 1'b1, 48, 1};
        vecs[3] = '{1'b1, 1'b1, 32, 1};

        resetn = 1'b0;
        en     = 1'b0;
        mode   = 1'b0;
        repeat (2) step();
        chk("rst_q_valid", row_t'(bus.q_valid), row_t'(0));
        chk("rst_q", bus.q, row_t'(0));
        chk("rst_q_cnt", row_t'(bus.q_cnt), row_t'(0));
        chk("rst_q_comp", row_t'(bus.q_comp), row_t'(0));
        chk("rst_q_blk", row_t'(bus.q_blk), row_t'(0));
        chk("rst_mcu_done", row_t'(bus.mcu_done), row_t'(0));
        chk("rst_holds", row_t'({bus.y_hold, bus.cb_hold, bus.cr_hold}), row_t'(3'b111));
        resetn = 1'b1;
        mon_on = 1'b1;
        step();

        // Table-driven single-MCU runs, with and without random stalls and valid gaps.
        for (int v = 0; v < 4; v++) begin
            x0     = n_xfer;
            d0     = n_done;
            rnd_en = vecs[v].rnd;
            run_mcu(vecs[v].mode);
            rnd_en = 1'b0;
            repeat (3) step();
            chk("vec_xfers", row_t'(n_xfer - x0), row_t'(vecs[v].exp_xfer));
            chk("vec_dones", row_t'(n_done - d0), row_t'(vecs[v].exp_done));
            chk("vec_idle_holds", row_t'({bus.y_hold, bus.cb_hold, bus.cr_hold}),
                row_t'(3'b111));
        end

        // Mode toggled mid-MCU only changes the following MCU.
        x0 = n_xfer;
        d0 = n_done;
        push_mcu(1'b1);
        push_mcu(1'b0);
        mode = 1'b1;
        en   = 1'b1;
        t    = 0;
        while (n_xfer - x0 < 20 && t < 500) begin step(); t++; end
        mode = 1'b0;
        while (n_xfer - x0 < 40 && t < 1000) begin step(); t++; end
        en = 1'b0;
        drain(2000);
        chk("toggle_xfers", row_t'(n_xfer - x0), row_t'(80));
        chk("toggle_dones", row_t'(n_done - d0), row_t'(2));

        // Five-cycle output stall on Y1 row 3.
        push_mcu(1'b0);
        mode = 1'b0;
        en   = 1'b1;
        step();
        en = 1'b0;
        wait_row(0, 1, 2);
        manual_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_q", bus.q, exp_q[0].data);
            chk("stall_q_cnt", row_t'(bus.q_cnt), row_t'(3));
            chk("stall_y_hold", row_t'(bus.y_hold), row_t'(1));
            chk("stall_cb_hold", row_t'(bus.cb_hold), row_t'(1));
        end
        manual_hold = 1'b0;
        step();
        chk("unstall_q_cnt", row_t'(bus.q_cnt), row_t'(3));
        step();
        chk("next_q_cnt", row_t'(bus.q_cnt), row_t'(4));
        chk("next_q_valid", row_t'(bus.q_valid), row_t'(1));
        drain(2000);

        // en dropped at Cb row 2: MCU finishes, scheduler idles, then restarts at Y0 row 0.
        d0 = n_done;
        push_mcu(1'b0);
        mode = 1'b0;
        en   = 1'b1;
        wait_row(1, 4, 2);
        en = 1'b0;
        drain(2000);
        repeat (3) step();
        chk("endrop_holds", row_t'({bus.y_hold, bus.cb_hold, bus.cr_hold}), row_t'(3'b111));
        chk("endrop_q_valid", row_t'(bus.q_valid), row_t'(0));
        chk("endrop_dones", row_t'(n_done - d0), row_t'(1));
        run_mcu(1'b0);

        // Reset pulsed mid-block at Y2 row 5.
        push_mcu(1'b0);
        mode = 1'b0;
        en   = 1'b1;
        wait_row(0, 2, 5);
        resetn = 1'b0;
        en     = 1'b0;
        step();
        chk("midrst_q_valid", row_t'(bus.q_valid), row_t'(0));
        chk("midrst_holds", row_t'({bus.y_hold, bus.cb_hold, bus.cr_hold}), row_t'(3'b111));
        resetn = 1'b1;
        exp_q.delete();
        mcnt[0] = y_sent;
        mcnt[1] = cb_sent;
        mcnt[2] = cr_sent;
        run_mcu(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
